obp_program_loader: RTL and testbench

Sequencer that programs and then releases one OneBitProcessor instance. It accepts parallel 13-bit instruction words from a host over a valid/ready handshake and issues a processor reset pulse. It serialises each word MSB-first onto the processor's IN0 line with enable asserted, then hands IN0/IN1 over to the external run-time inputs. It sits between host or test logic and the processor's clk/reset/en/inReg ports.

---
 rtl/obp_pkg.sv | 20 ++
 rtl/obp_piso_shift.sv | 49 ++++
 rtl/obp_program_loader.sv | 133 +++++++++++++
 tb/tb_obp_program_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/obp_pkg.sv
// Shared constants and types for the OneBitProcessor program loader.
// The top module re-declares the sizing values as parameters defaulting to these.
package obp_pkg;

  localparam int INSTR_W  = 13;
  localparam int PROG_LEN = 16;
  localparam int IN_REGS  = 2;
  localparam int OUT_REGS = 7;

  typedef enum logic [2:0] {
    IDLE,
    RESET_PROC,
    LOAD_WAIT,
    SHIFT,
    RUN
  } state_t;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/obp_piso_shift.sv
// Parallel-load, MSB-first shift register with a down-counting bit counter.
// Next-cycle MSB and last-bit flags let the parent register its outputs.
module obp_piso_shift #(
  parameter int W = obp_pkg::INSTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_last,
  output logic         o_msb_nxt,
  output logic         o_last_nxt
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_shreg;
  logic [W-1:0]  w_shreg_nxt;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_bit_cnt_nxt;

  always_comb begin
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    if (i_load) begin
      w_shreg_nxt   = i_data;
      w_bit_cnt_nxt = CW'(W - 1);
    end else if (i_shift) begin
      w_shreg_nxt   = r_shreg << 1;
      w_bit_cnt_nxt = r_bit_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  assign o_last     = (r_bit_cnt == '0);
  assign o_msb_nxt  = w_shreg_nxt[W-1];
  assign o_last_nxt = (w_bit_cnt_nxt == '0);

endmodule

// File: rtl/obp_program_loader.sv
// Programs a OneBitProcessor by shifting host words MSB-first onto IN0, then
// releases it to run with the external inputs. All outputs are registered.
//
// state      | meaning
// IDLE       | processor untouched, inputs held at 0
// RESET_PROC | one-cycle processor reset pulse, word count cleared
// LOAD_WAIT  | waiting for the next host word, IN1 high keeps program paused
// SHIFT      | shifting the current word out with enable high
// RUN        | program loaded, ext_in passed through
module obp_program_loader #(
  parameter int INSTR_W  = obp_pkg::INSTR_W,
  parameter int PROG_LEN = obp_pkg::PROG_LEN,
  parameter int IN_REGS  = obp_pkg::IN_REGS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [INSTR_W-1:0]            word_data,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic [IN_REGS-1:0]            ext_in,
  output logic                          proc_reset,
  output logic                          proc_en,
  output logic [IN_REGS-1:0]            proc_in,
  output logic                          loading,
  output logic                          done,
  output logic [$clog2(PROG_LEN+1)-1:0] word_cnt
);

  import obp_pkg::*;

  localparam int CNT_W = $clog2(PROG_LEN + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_word_cnt, w_cnt_nxt;
  logic               r_word_ready, w_ready_nxt;
  logic               r_proc_reset, r_proc_en, r_loading, r_done;
  logic [IN_REGS-1:0] r_proc_in, w_in_nxt;
  logic               w_accept, w_load, w_shift;
  logic               w_last_bit, w_msb_nxt, w_last_nxt;

  // word_ready is only ever high in LOAD_WAIT or on a final SHIFT bit
  assign w_accept = word_valid && r_word_ready;

  obp_piso_shift #(.W(INSTR_W)) u_piso (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (word_data),
    .o_last     (w_last_bit),
    .o_msb_nxt  (w_msb_nxt),
    .o_last_nxt (w_last_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_word_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE:       if (start) w_state_nxt = RESET_PROC;
      RESET_PROC: w_state_nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
          w_cnt_nxt = (r_word_cnt == CNT_W'(PROG_LEN)) ? r_word_cnt : r_word_cnt + 1'b1;
          if (w_cnt_nxt == CNT_W'(PROG_LEN)) w_state_nxt = RUN;
          else if (w_accept)                 w_load      = 1'b1;
          else                               w_state_nxt = LOAD_WAIT;
        end else begin
          w_shift = 1'b1;
        end
      end
      RUN:        if (start) w_state_nxt = RESET_PROC;
      default:    w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == RESET_PROC) w_cnt_nxt = '0;
  end

  // Outputs are precomputed from the next state so they line up with it
  always_comb begin
    w_ready_nxt = (w_state_nxt == LOAD_WAIT) ||
                  ((w_state_nxt == SHIFT) && w_last_nxt && (w_cnt_nxt != CNT_W'(PROG_LEN - 1)));
    w_in_nxt = '0;
    case (w_state_nxt)
      RESET_PROC, LOAD_WAIT: w_in_nxt[1] = 1'b1;
      SHIFT: begin
        w_in_nxt[1] = 1'b1;
        w_in_nxt[0] = w_msb_nxt;
      end
      RUN:     w_in_nxt = ext_in;
      default: w_in_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word_cnt   <= '0;
      r_word_ready <= 1'b0;
      r_proc_reset <= 1'b0;
      r_proc_en    <= 1'b0;
      r_proc_in    <= '0;
      r_loading    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_cnt   <= w_cnt_nxt;
      r_word_ready <= w_ready_nxt;
      r_proc_reset <= (w_state_nxt == RESET_PROC);
      r_proc_en    <= (w_state_nxt == SHIFT);
      r_proc_in    <= w_in_nxt;
      r_loading    <= (w_state_nxt == RESET_PROC) || (w_state_nxt == LOAD_WAIT) ||
                      (w_state_nxt == SHIFT);
      r_done       <= (w_state_nxt == RUN);
    end
  end

  assign word_ready = r_word_ready;
  assign proc_reset = r_proc_reset;
  assign proc_en    = r_proc_en;
  assign proc_in    = r_proc_in;
  assign loading    = r_loading;
  assign done       = r_done;
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_obp_program_loader.sv
// Scoreboard bench: accepted words push their bits, each enabled cycle pops one.
// A small phase model predicts word_cnt, done, proc_reset, loading and passthrough.
module tb_obp_program_loader;
  import obp_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset, start, word_valid;
  logic [INSTR_W-1:0]   word_data;
  logic [IN_REGS-1:0]   ext_in;
  logic                 word_ready, proc_reset, proc_en, loading, done;
  logic [IN_REGS-1:0]   proc_in;
  logic [$clog2(PROG_LEN+1)-1:0] word_cnt;

  obp_program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ext_in     (ext_in),
    .proc_reset (proc_reset),
    .proc_en    (proc_en),
    .proc_in    (proc_in),
    .loading    (loading),
    .done       (done),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit b; bit last; } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0;
  int m_cnt = 0;
  bit m_done = 0, m_idle = 1, m_preset = 0;
  logic [IN_REGS-1:0] m_ext = '0;
  int en_total, en_run, en_max, preset_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_stats();
    en_total = 0; en_run = 0; en_max = 0; preset_cnt = 0;
  endtask

  // Inputs for the cycle are already driven; update model, cross the edge, check.
  task automatic cyc();
    exp_t e;
    if (reset) begin
      q.delete();
      m_cnt = 0; m_done = 0; m_idle = 1; m_preset = 0;
    end else begin
      if (start && (m_idle || m_done)) begin
        m_cnt = 0; m_done = 0; m_idle = 0; m_preset = 1;
      end
      if (word_valid && word_ready) begin
        for (int i = INSTR_W - 1; i >= 0; i--) begin
          e.b = word_data[i];
          e.last = (i == 0);
          q.push_back(e);
        end
      end
    end
    m_ext = ext_in;
    @(negedge clk);
    chk("proc_reset", proc_reset, m_preset);
    m_preset = 0;
    chk("word_cnt", word_cnt, m_cnt);
    chk("done", done, m_done);
    chk("loading", loading, !(m_idle || m_done));
    chk("proc_en", proc_en, q.size() != 0);
    if (m_idle) chk("idle_in", proc_in, 0);
    if (m_done) chk("run_in", proc_in, m_ext);
    if (m_idle || m_done) chk("ready_off", word_ready, 0);
    if (proc_reset) preset_cnt++;
    if (proc_en) begin
      en_total++; en_run++;
      if (en_run > en_max) en_max = en_run;
    end else en_run = 0;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("bit", proc_in[0], e.b);
      chk("in1", proc_in[1], 1);
      if (e.last) begin
        m_cnt++;
        if (m_cnt == PROG_LEN) m_done = 1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Leaves word_valid high so back-to-back calls form a gapless stream.
  task automatic send_word(input logic [INSTR_W-1:0] w, input bit with_start);
    bit got;
    int t;
    got = 0; t = 0;
    word_valid = 1'b1;
    word_data  = w;
    start      = with_start;
    while (!got && t < 40) begin
      got = word_ready;
      cyc();
      start = 1'b0;
      t++;
    end
    if (!got) chk("handshake_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 40) begin
      cyc();
      t++;
    end
    chk("done_reached", done, 1);
  endtask

  function automatic logic [INSTR_W-1:0] pat(input int i);
    case (i % 4)
      0:       return 13'h1FFF;
      1:       return 13'h0000;
      2:       return 13'h1555;
      default: return 13'h0AAA;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; word_valid = 1'b1; word_data = 13'h1234; ext_in = '0;
    cyc(); cyc();
    reset = 1'b0;
    repeat (3) cyc();
    word_valid = 1'b0;

    // Single word, bit order
    clr_stats();
    pulse_start();
    send_word(13'b1010101010101, 1'b0);
    word_valid = 1'b0;
    repeat (14) cyc();
    chk("cnt_one_word", word_cnt, 1);
    chk("en_one_word", en_total, INSTR_W);
    chk("preset_pulse", preset_cnt, 1);
    reset = 1'b1; cyc(); reset = 1'b0; cyc();

    // Full gapless stream with an ignored start mid-shift
    clr_stats();
    pulse_start();
    for (int i = 0; i < PROG_LEN; i++) send_word(pat(i), i == 5);
    word_valid = 1'b0;
    wait_done();
    chk("en_consecutive", en_max, PROG_LEN * INSTR_W);
    chk("en_total_full", en_total, PROG_LEN * INSTR_W);
    chk("cnt_full", word_cnt, PROG_LEN);
    chk("preset_once", preset_cnt, 1);

    // Run passthrough
    ext_in = 2'b10; cyc();
    ext_in = 2'b01; cyc();
    ext_in = 2'b11; cyc(); cyc();
    chk("run_en_low", proc_en, 0);

    // Restart from RUN with a host gap after the third word
    clr_stats();
    pulse_start();
    for (int i = 0; i < PROG_LEN; i++) begin
      send_word(pat(i + 1), 1'b0);
      if (i == 2) begin
        word_valid = 1'b0;
        repeat (INSTR_W + 5) cyc();
      end
    end
    word_valid = 1'b0;
    wait_done();
    chk("en_total_gap", en_total, PROG_LEN * INSTR_W);
    chk("gap_seen", en_max < PROG_LEN * INSTR_W, 1);

    // Reset in the middle of word 7, then start and reset together
    pulse_start();
    for (int i = 0; i < 7; i++) send_word(pat(i + 2), 1'b0);
    word_valid = 1'b0;
    repeat (4) cyc();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    chk("reset_mid_en", proc_en, 0);
    chk("reset_mid_cnt", word_cnt, 0);
    reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0; start = 1'b0; cyc();
    chk("reset_wins", loading, 0);

    // Fresh program with random words
    clr_stats();
    pulse_start();
    chk("restart_cnt", word_cnt, 0);
    for (int i = 0; i < PROG_LEN; i++)
      send_word(INSTR_W'($urandom_range(0, (1 << INSTR_W) - 1)), 1'b0);
    word_valid = 1'b0;
    wait_done();
    chk("en_total_rand", en_total, PROG_LEN * INSTR_W);
    ext_in = 2'b10; cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
